// File: rtl/regfile_port_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_ctrl_if
//  Description : Debug requester handshake bundle for regfile_port_ctrl.
//                The requester (master) raises req with wr/addr/wdata held
//                alongside. The controller (slave) answers with a one-cycle
//                ack, and rdata is valid while ack is high.
//  Signals     : req   - access request (level)
//                wr    - 1 = write, 0 = read (sampled with req)
//                addr  - register index
//                wdata - write data
//                ack   - one-cycle completion pulse
//                rdata - read result, valid with ack
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_ctrl_if;
  logic        req;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_ctrl
//  Description : Sequencer/arbiter for the register file write port (A3/WD3/
//                WE3) and read port 1 (A1/RD1). After reset it optionally
//                sweeps x1..x31 to RESET_VAL. It then passes pipeline
//                writebacks through and serves a debug requester, stalling
//                the pipeline while the debug access owns the ports.
//  Build macro : RF_CLEAR_ON_RESET_EN - enables the post-reset clear sweep
//                (INIT state). Without it the block resets straight into IDLE
//                and init_done is constantly high.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                wb_we/wb_addr/wb_data - pipeline writeback
//                pipe_a1            - pipeline read address, port 1
//                rf_rd1             - register file RD1 return
//                rf_we/rf_a3/rf_wd3 - register file write port
//                rf_a1              - register file read address, port 1
//                stall              - freezes the pipeline
//                init_done          - clear sweep complete
//                dbg                - debug req/ack handshake (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_ctrl #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         wb_we,
  input  wire  [4:0]  wb_addr,
  input  wire  [31:0] wb_data,
  input  wire  [4:0]  pipe_a1,
  input  wire  [31:0] rf_rd1,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic [4:0]  rf_a1,
  output logic        stall,
  output logic        init_done,
  regfile_port_ctrl_if.slave dbg
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_DRAIN  = 3'd2,
    S_ACCESS = 3'd3,
    S_ACK    = 3'd4
  } state_t;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam state_t C_RST_STATE = S_INIT;
`else
  localparam state_t C_RST_STATE = S_IDLE;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic        r_dbg_ack;
  logic [31:0] r_dbg_rdata;
  logic        r_lat_wr;
  logic [4:0]  r_lat_addr;
  logic [31:0] r_lat_wdata;
  logic        w_wb_write;

  // x0 is hard-wired in the register file, so a write to it is never issued.
  assign w_wb_write = wb_we && (wb_addr != 5'd0);

  // --------------------------------------------------------------------------
  // Main state register, debug latches and debug response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= C_RST_STATE;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= 32'h0;
      r_lat_wr    <= 1'b0;
      r_lat_addr  <= 5'd0;
      r_lat_wdata <= 32'h0;
    end else begin
      r_state   <= w_next_state;
      // ACCESS is always followed by ACK, so the ack pulse is simply the
      // registered "was in ACCESS" flag.
      r_dbg_ack <= (r_state == S_ACCESS);
      // RD1 is sampled at the edge closing ACCESS; a pipeline write landed in
      // DRAIN is therefore visible to the debug read.
      if (r_state == S_ACCESS) begin
        r_dbg_rdata <= rf_rd1;
      end
      if ((r_state == S_IDLE) && dbg.req) begin
        r_lat_wr    <= dbg.wr;
        r_lat_addr  <= dbg.addr;
        r_lat_wdata <= dbg.wdata;
      end
    end
  end

`ifdef RF_CLEAR_ON_RESET_EN
  logic [4:0] r_cnt;
  logic       r_init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 5'd1;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_init_done <= 1'b1;
      end
    end
  end

  assign init_done = r_init_done;
`else
  assign init_done = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Next state and port steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    rf_we        = 1'b0;
    rf_a3        = wb_addr;
    rf_wd3       = wb_data;
    rf_a1        = pipe_a1;
    stall        = 1'b1;

    case (r_state)
`ifdef RF_CLEAR_ON_RESET_EN
      S_INIT: begin
        rf_we  = 1'b1;
        rf_a3  = r_cnt;
        rf_wd3 = RESET_VAL;
        if (r_cnt == 5'd31) begin
          w_next_state = S_IDLE;
        end
      end
`endif
      S_IDLE: begin
        stall = 1'b0;
        rf_we = w_wb_write;
        if (dbg.req) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The instruction already in writeback is allowed to retire.
        rf_we        = w_wb_write;
        w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        // Debug owns both ports; any pipeline writeback here is dropped.
        rf_a1        = r_lat_addr;
        rf_a3        = r_lat_addr;
        rf_wd3       = r_lat_wdata;
        rf_we        = r_lat_wr && (r_lat_addr != 5'd0);
        w_next_state = S_ACK;
      end
      S_ACK: begin
        w_next_state = S_IDLE;
      end
      default: begin
        // Unused encodings: issue no write, park the data bus on the reset
        // value and recover to IDLE.
        rf_wd3       = RESET_VAL;
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign dbg.ack   = r_dbg_ack;
  assign dbg.rdata = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_port_ctrl
//  Description : Self-checking bench for regfile_port_ctrl with a behavioural
//                32x32 register file (negedge write, combinational RD1, x0
//                reads 0, x5 reads the trigger value).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_ctrl;

  localparam logic [31:0] RESET_VAL = 32'h0;
  localparam logic [31:0] TRIGGER   = 32'h5A5A_0005;
`ifdef RF_CLEAR_ON_RESET_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  pipe_a1;
  logic [31:0] rf_rd1;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  rf_a1;
  logic        stall;
  logic        init_done;

  regfile_port_ctrl_if dbg_if ();

  regfile_port_ctrl #(.RESET_VAL(RESET_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pipe_a1   (pipe_a1),
    .rf_rd1    (rf_rd1),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_a1     (rf_a1),
    .stall     (stall),
    .init_done (init_done),
    .dbg       (dbg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file
  logic [31:0] rf_mem [32];
  logic        mem_init = 1'b0;
  int          x0_writes = 0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hFFFF_FFFF;
      mem_init <= 1'b1;
    end else if (rf_we) begin
      if (rf_a3 == 5'd0) x0_writes <= x0_writes + 1;
      else               rf_mem[rf_a3] <= rf_wd3;
    end
  end

  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'h0 : (rf_a1 == 5'd5) ? TRIGGER : rf_mem[rf_a1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  a1;
    logic        exp_we;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Entry: posedge+2 of an IDLE cycle. Runs one full debug transaction.
  task automatic dbg_seq(input string tag, input logic wr, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic dwe, input logic [4:0] dad,
                         input logic [31:0] ddat, input logic [31:0] exp_rd, input logic chk_rd);
    dbg_if.req = 1'b1; dbg_if.wr = wr; dbg_if.addr = addr; dbg_if.wdata = wdata;
    #1;
    check({tag, "_idle_stall"}, {31'b0, stall}, 32'd0);
    @(posedge clk); #1;                         // edge k -> DRAIN
    dbg_if.req = 1'b0; dbg_if.wr = 1'b0; dbg_if.addr = 5'd0; dbg_if.wdata = 32'h0;
    wb_we = dwe; wb_addr = dad; wb_data = ddat;
    #1;
    check({tag, "_drain_stall"}, {31'b0, stall}, 32'd1);
    check({tag, "_drain_ack"}, {31'b0, dbg_if.ack}, 32'd0);
    check({tag, "_drain_we"}, {31'b0, rf_we}, {31'b0, dwe && (dad != 5'd0)});
    @(posedge clk); #1;                         // ACCESS
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hBAD0_0009;
    #1;
    check({tag, "_acc_stall"}, {31'b0, stall}, 32'd1);
    check({tag, "_acc_a1"}, {27'b0, rf_a1}, {27'b0, addr});
    check({tag, "_acc_we"}, {31'b0, rf_we}, {31'b0, wr && (addr != 5'd0)});
    if (wr) begin
      check({tag, "_acc_a3"}, {27'b0, rf_a3}, {27'b0, addr});
      check({tag, "_acc_wd3"}, rf_wd3, wdata);
    end
    @(posedge clk); #1;                         // ACK
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    #1;
    check({tag, "_ack"}, {31'b0, dbg_if.ack}, 32'd1);
    check({tag, "_ack_stall"}, {31'b0, stall}, 32'd1);
    check({tag, "_ack_we"}, {31'b0, rf_we}, 32'd0);
    if (chk_rd) check({tag, "_rdata"}, dbg_if.rdata, exp_rd);
    @(posedge clk); #2;                         // back in IDLE
    check({tag, "_end_ack"}, {31'b0, dbg_if.ack}, 32'd0);
    check({tag, "_end_stall"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    int acks;
    int first;
    logic [31:0] got_rd;

    vecs[0] = '{1'b1, 5'd10, 32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hCAFE_F00D, 5'd10, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 5'd12, 32'h0000_1111, 5'd0,  1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 5'd5,  32'h0000_0077, 5'd31, 1'b1, 1'b1, 32'h8000_0001};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd5,  1'b0, 1'b1, TRIGGER};
    vecs[6] = '{1'b1, 5'd1,  32'h0000_ABCD, 5'd1,  1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 5'd1,  32'h0,         5'd1,  1'b0, 1'b1, 32'h0000_ABCD};

    rst_n = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; pipe_a1 = 5'd0;
    dbg_if.req = 1'b0; dbg_if.wr = 1'b0; dbg_if.addr = 5'd0; dbg_if.wdata = 32'h0;

    // ---------------- Reset state ----------------
    @(posedge clk); @(posedge clk); #2;
    check("rst_stall", {31'b0, stall}, {31'b0, SWEEP});
    check("rst_init_done", {31'b0, init_done}, {31'b0, !SWEEP});
    check("rst_we", {31'b0, rf_we}, {31'b0, SWEEP});
    check("rst_a3", {27'b0, rf_a3}, SWEEP ? 32'd1 : 32'd0);
    check("rst_ack", {31'b0, dbg_if.ack}, 32'd0);
    check("rst_rdata", dbg_if.rdata, 32'h0);

    rst_n = 1'b1;
    #1;
`ifdef RF_CLEAR_ON_RESET_EN
    // ---------------- Clear sweep ----------------
    for (int i = 1; i <= 31; i++) begin
      check("sweep_we", {31'b0, rf_we}, 32'd1);
      check("sweep_a3", {27'b0, rf_a3}, i);
      check("sweep_wd3", rf_wd3, RESET_VAL);
      check("sweep_stall", {31'b0, stall}, 32'd1);
      check("sweep_init_done", {31'b0, init_done}, 32'd0);
      @(posedge clk); #2;
    end
    pipe_a1 = 5'd10;
    #1;
    check("sweep_x10", rf_rd1, RESET_VAL);
`endif
    check("idle_init_done", {31'b0, init_done}, 32'd1);
    check("idle_stall", {31'b0, stall}, 32'd0);

    // ---------------- Pass-through table ----------------
    @(posedge clk); #2;
    foreach (vecs[i]) begin
      wb_we = vecs[i].we; wb_addr = vecs[i].addr; wb_data = vecs[i].data; pipe_a1 = vecs[i].a1;
      #1;
      check("pt_we", {31'b0, rf_we}, {31'b0, vecs[i].exp_we});
      check("pt_a3", {27'b0, rf_a3}, {27'b0, vecs[i].addr});
      check("pt_wd3", rf_wd3, vecs[i].data);
      check("pt_a1", {27'b0, rf_a1}, {27'b0, vecs[i].a1});
      check("pt_stall", {31'b0, stall}, 32'd0);
      if (vecs[i].chk_rd) check("pt_rd1", rf_rd1, vecs[i].exp_rd);
      @(posedge clk); #2;
    end
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; pipe_a1 = 5'd0;
    @(posedge clk); #2;

    // ---------------- Debug sequences ----------------
    dbg_seq("dwr7", 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    dbg_seq("drd7", 1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1234_5678, 1'b1);
    dbg_seq("drain3", 1'b0, 5'd3, 32'h0, 1'b1, 5'd3, 32'h0000_00A5, 32'h0000_00A5, 1'b1);
    dbg_seq("dwr0", 1'b1, 5'd0, 32'h7777_7777, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    dbg_seq("drd5", 1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0, TRIGGER, 1'b1);
    dbg_seq("drd0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

    // ---------------- Reset during ACCESS ----------------
    wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'h0000_2222;
    @(posedge clk); #2;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    dbg_if.req = 1'b1; dbg_if.wr = 1'b1; dbg_if.addr = 5'd20; dbg_if.wdata = 32'h0000_9999;
    @(posedge clk); #1;                         // DRAIN
    dbg_if.req = 1'b0;
    @(posedge clk); #2;                         // ACCESS, before the write negedge
    check("rac_acc_we", {31'b0, rf_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rac_ack", {31'b0, dbg_if.ack}, 32'd0);
    check("rac_init_done", {31'b0, init_done}, {31'b0, !SWEEP});
    check("rac_stall", {31'b0, stall}, {31'b0, SWEEP});
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      acks += int'(dbg_if.ack);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= (SWEEP ? 32 : 4); c++) begin
      acks += int'(dbg_if.ack);
      if (c < (SWEEP ? 32 : 4)) check("rac_init_low", {31'b0, init_done}, {31'b0, !SWEEP});
      else                      check("rac_init_high", {31'b0, init_done}, 32'd1);
      if (c < (SWEEP ? 32 : 4)) begin @(posedge clk); #2; end
    end
    check("rac_no_ack", acks, 0);
    pipe_a1 = 5'd20;
    #1;
    check("rac_x20", rf_rd1, SWEEP ? RESET_VAL : 32'h0000_2222);
    pipe_a1 = 5'd0;

    // ---------------- dbg_req held through reset ----------------
    @(posedge clk); #2;
    rst_n = 1'b0;
    dbg_if.req = 1'b1; dbg_if.wr = 1'b0; dbg_if.addr = 5'd10; dbg_if.wdata = 32'h0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    first = 0; got_rd = 32'h0;
    for (int c = 1; c <= 45; c++) begin
      if (dbg_if.ack && first == 0) begin
        first = c; got_rd = dbg_if.rdata; dbg_if.req = 1'b0;
      end
      @(posedge clk); #2;
    end
    dbg_if.req = 1'b0;
    check("held_ack_cycle", first, SWEEP ? 35 : 4);
    check("held_rdata", got_rd, SWEEP ? RESET_VAL : 32'hDEAD_BEEF);
    check("held_end_stall", {31'b0, stall}, 32'd0);

    check("x0_never_written", x0_writes, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
